// File: rtl/float_selector_pipe.sv
// float_selector_pipe: elastic IEEE-754 MIN/MAX selector pipeline with tag sideband.
// Define FPU_SEL_NAN_PROP_EN to also accept NaN-propagating MINIMUM/MAXIMUM.
package FPU_pkg;
  localparam logic [4:0] FPU_OP_ADD     = 5'd0;
  localparam logic [4:0] FPU_OP_MIN     = 5'd8;
  localparam logic [4:0] FPU_OP_MAX     = 5'd9;
  localparam logic [4:0] FPU_OP_MINIMUM = 5'd10;
  localparam logic [4:0] FPU_OP_MAXIMUM = 5'd11;
endpackage

module float_selector_pipe
  import FPU_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             valid_out,
  input  logic             ready_in,
  input  logic [4:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [TAG_W-1:0] tag_in,
  output logic [W-1:0]     float_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             IV
);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic [STAGES-1:0] r_v;
  logic [W-1:0]      r_res [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [STAGES-1:0] r_iv;
  logic [STAGES-1:0] w_go;
  logic              w_chain;
  logic              w_a_nan, w_b_nan, w_a_lt, w_max, w_op_ok, w_all_nan, w_acc;
  logic [W-1:0]      w_sel;
  assign w_a_nan = &a[W-2:MAN_W] & |a[MAN_W-1:0];
  assign w_b_nan = &b[W-2:MAN_W] & |b[MAN_W-1:0];
  // signed-magnitude order: differing signs decide alone, so -0 < +0
  assign w_a_lt = (a[W-1] != b[W-1]) ? a[W-1] :
                  a[W-1] ? (a[W-2:0] > b[W-2:0]) : (a[W-2:0] < b[W-2:0]);
`ifdef FPU_SEL_NAN_PROP_EN
  assign w_op_ok   = (op == FPU_OP_MIN) | (op == FPU_OP_MAX) | (op == FPU_OP_MINIMUM) | (op == FPU_OP_MAXIMUM);
  assign w_max     = (op == FPU_OP_MAX) | (op == FPU_OP_MAXIMUM);
  assign w_all_nan = (w_a_nan & w_b_nan) | ((w_a_nan | w_b_nan) & ((op == FPU_OP_MINIMUM) | (op == FPU_OP_MAXIMUM)));
`else
  assign w_op_ok   = (op == FPU_OP_MIN) | (op == FPU_OP_MAX);
  assign w_max     = op == FPU_OP_MAX;
  assign w_all_nan = w_a_nan & w_b_nan;
`endif
  assign w_sel = w_all_nan ? QNAN : w_a_nan ? b : w_b_nan ? a : (w_a_lt ^ w_max) ? a : b;
  // a stage may load when it is empty or everything downstream of it drains
  always_comb begin
    w_go = '0;
    w_chain = ~r_v[STAGES-1] | ready_in;
    w_go[STAGES-1] = w_chain;
    for (int s = STAGES - 2; s >= 0; s--) begin
      w_chain = ~r_v[s] | w_chain;
      w_go[s] = w_chain;
    end
  end
  assign ready_out = w_go[0];
  assign w_acc     = valid_in & w_go[0] & w_op_ok;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
    end else begin
      if (w_go[0]) begin
        r_v[0]   <= w_acc;
        r_res[0] <= w_sel;
        r_tag[0] <= tag_in;
        r_iv[0]  <= (w_a_nan & ~a[MAN_W-1]) | (w_b_nan & ~b[MAN_W-1]);
      end
      for (int s = 1; s < STAGES; s++)
        if (w_go[s]) begin
          r_v[s]   <= r_v[s-1];
          r_res[s] <= r_res[s-1];
          r_tag[s] <= r_tag[s-1];
          r_iv[s]  <= r_iv[s-1];
        end
    end
  end
  assign valid_out = r_v[STAGES-1];
  assign float_out = valid_out ? r_res[STAGES-1] : '0;
  assign tag_out   = valid_out ? r_tag[STAGES-1] : '0;
  assign IV        = valid_out & r_iv[STAGES-1];
endmodule

// File: tb/tb_float_selector_pipe.sv
// tb_float_selector_pipe: directed checks of float_selector_pipe at default parameters.
module tb_float_selector_pipe;
  import FPU_pkg::*;
  logic        clk = 0, reset = 1, valid_in = 0, ready_in = 1;
  logic        ready_out, valid_out, iv;
  logic [4:0]  op = FPU_OP_MIN;
  logic [31:0] a = '0, b = '0, float_out;
  logic [3:0]  tag_in = '0, tag_out;
  logic [31:0] exp_f [8];
  int          n_chk = 0, n_pass = 0, n_got = 0;
  bit          mon_en = 0;
  always #5 clk = ~clk;
  float_selector_pipe dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .valid_out(valid_out), .ready_in(ready_in), .op(op), .a(a), .b(b),
    .tag_in(tag_in), .float_out(float_out), .tag_out(tag_out), .IV(iv)
  );
  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", t, got, want);
  endtask
  task automatic run1(input string t, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [3:0] tg, input logic [31:0] ef, input logic ei);
    op = o; a = x; b = y; tag_in = tg; valid_in = 1;
    @(posedge clk); #1 valid_in = 0;
    @(negedge clk); chk({t, "_lat"}, valid_out, 0);
    @(posedge clk); @(negedge clk);
    chk({t, "_v"}, valid_out, 1);
    chk({t, "_f"}, float_out, ef);
    chk({t, "_tag"}, tag_out, tg);
    chk({t, "_iv"}, iv, ei);
    @(posedge clk); #1;
  endtask
  task automatic no_out(input string t, input logic [4:0] o);
    logic seen;
    op = o; a = 32'h7fc00000; b = 32'h3f800000; tag_in = 4'hc; valid_in = 1;
    repeat (2) @(posedge clk);
    #1 valid_in = 0;
    seen = 0;
    repeat (4) begin @(negedge clk); seen |= valid_out; end
    chk(t, seen, 0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk)
    if (mon_en && valid_out && ready_in) begin
      if (n_got < 8) begin
        chk("bp_f", float_out, exp_f[n_got]);
        chk("bp_tag", tag_out, 4'(n_got));
      end else chk("bp_extra", valid_out, 0);
      n_got++;
    end
  initial begin
    int  i, cyc;
    logic acc, seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_vo", valid_out, 0); chk("rst_f", float_out, 0); chk("rst_tag", tag_out, 0); chk("rst_iv", iv, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk); chk("rst_ro", ready_out, 1);
    @(posedge clk); #1;
    run1("min_basic", FPU_OP_MIN, 32'h3f800000, 32'h40000000, 4'd5, 32'h3f800000, 0);
    run1("max_zero", FPU_OP_MAX, 32'h80000000, 32'h00000000, 4'd6, 32'h00000000, 0);
    run1("min_zero", FPU_OP_MIN, 32'h80000000, 32'h00000000, 4'd7, 32'h80000000, 0);
    run1("min_zero_r", FPU_OP_MIN, 32'h00000000, 32'h80000000, 4'd8, 32'h80000000, 0);
    run1("min_snan", FPU_OP_MIN, 32'h7f800001, 32'h40400000, 4'd9, 32'h40400000, 1);
    run1("max_qnan2", FPU_OP_MAX, 32'h7fc00000, 32'hffc00000, 4'ha, 32'h7fc00000, 0);
    run1("max_bnan", FPU_OP_MAX, 32'h40000000, 32'h7fc00000, 4'hb, 32'h40000000, 0);
    run1("nan2_snan", FPU_OP_MIN, 32'h7f800001, 32'hffc00000, 4'hd, 32'h7fc00000, 1);
    run1("min_neg", FPU_OP_MIN, 32'hbf800000, 32'hc0000000, 4'he, 32'hc0000000, 0);
    run1("max_neg", FPU_OP_MAX, 32'hbf800000, 32'hc0000000, 4'hf, 32'hbf800000, 0);
    for (int k = 0; k < 8; k++) exp_f[k] = (k % 2) ? (32'h40000000 | k) : (32'h3f800000 | k);
    mon_en = 1; n_got = 0; i = 0; cyc = 0;
    while (i < 8 && cyc < 40) begin
      ready_in = !(cyc >= 3 && cyc < 8);
      op = (i % 2) ? FPU_OP_MAX : FPU_OP_MIN;
      a = {1'b0, 8'h80, 23'(i)}; b = {1'b0, 8'h7f, 23'(i)}; tag_in = 4'(i); valid_in = 1;
      @(negedge clk);
      if (cyc == 5) begin chk("bp_full_ro", ready_out, 0); chk("bp_hold_tag", tag_out, 1); end
      if (cyc == 7) begin chk("bp_hold_tag2", tag_out, 1); chk("bp_hold_f", float_out, 32'h40000001); end
      acc = ready_out;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    valid_in = 0; ready_in = 1;
    chk("bp_sent", i, 8);
    repeat (10) @(negedge clk);
    chk("bp_count", n_got, 8);
    chk("bp_idle", valid_out, 0);
    mon_en = 0;
    @(posedge clk); #1;
    op = FPU_OP_MIN; a = 32'h3f800000; b = 32'h40000000; tag_in = 4'd1; valid_in = 1;
    @(posedge clk); #1 tag_in = 4'd2;
    @(posedge clk); #1 valid_in = 0; reset = 1;
    @(negedge clk); chk("rst2_pre", valid_out, 1);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rst2_vo", valid_out, 0); chk("rst2_f", float_out, 0); chk("rst2_ro", ready_out, 1);
    seen = 0;
    repeat (4) begin @(negedge clk); seen |= valid_out; end
    chk("rst2_stale", seen, 0);
    @(posedge clk); #1;
    no_out("add_ignored", FPU_OP_ADD);
`ifdef FPU_SEL_NAN_PROP_EN
    run1("minimum", FPU_OP_MINIMUM, 32'h7fc00000, 32'h3f800000, 4'd3, 32'h7fc00000, 0);
`else
    no_out("minimum_off", FPU_OP_MINIMUM);
`endif
    run1("after_all", FPU_OP_MAX, 32'h3f800000, 32'h40000000, 4'd4, 32'h40000000, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/float_selector_pipe.md
FLOAT_SELECTOR_PIPE -- requirements
Module: float_selector_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width; operand width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter STAGES, default 2, number of pipeline stages; legal range 1..4.
REQ-004 SHALL have parameter TAG_W, default 4, width of the sideband tag.
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port valid_in, input, 1, upstream request valid.
REQ-008 SHALL have port ready_out, output, 1, block can accept a request this cycle.
REQ-009 SHALL have port valid_out, output, 1, result valid.
REQ-010 SHALL have port ready_in, input, 1, downstream accepts result.
REQ-011 SHALL have port op, input, 5, FPU_pkg operation code.
REQ-012 SHALL have ports a and b, input, W each, IEEE-754 operands.
REQ-013 SHALL have port tag_in, input, TAG_W, sideband carried with the request.
REQ-014 SHALL have port float_out, output, W, selected result.
REQ-015 SHALL have port tag_out, output, TAG_W, tag of the request in float_out.
REQ-016 SHALL have port IV, output, 1, invalid-operation flag for the result.

Function
REQ-017 SHALL transfer a request when valid_in && ready_out && op in {FPU_OP_MIN, FPU_OP_MAX} (plus REQ-032 ops if enabled); requests with any other op SHALL NOT enter the pipeline and SHALL NOT affect state.
REQ-018 SHALL implement an elastic pipeline of STAGES registers, each with its own valid bit; a stage loads when it is empty or its contents move forward the same cycle.
REQ-019 ready_out SHALL be 1 when stage 0 is empty or stage 0 advances this cycle; it SHALL NOT depend on valid_in or op.
REQ-020 Latency SHALL be exactly STAGES cycles from accepted request to valid_out with ready_in held 1; throughput SHALL be one result per cycle.
REQ-021 With valid_out=1 and ready_in=0, float_out, tag_out, IV SHALL hold stable and no stored request SHALL be lost or duplicated; when full, ready_out SHALL be 0.
REQ-022 Simultaneous accept at input and retire at output while full SHALL be permitted (no bubble).
REQ-023 Comparison, NaN classification and selection SHALL be evaluated in stage 0; later stages only carry result, tag, IV.
REQ-024 sNaN: exponent all ones, mantissa nonzero, mantissa MSB 0; qNaN: exponent all ones, mantissa MSB 1.
REQ-025 IV SHALL be 1 iff either operand is sNaN.
REQ-026 Both operands NaN: result SHALL be canonical qNaN {0, all-ones exponent, 1, zeros} (32'h7fc00000 at default widths).
REQ-027 Exactly one operand NaN: result SHALL be the other operand, for both MIN and MAX.
REQ-028 MIN: numerically smaller operand; MAX: larger; ordering over signed magnitude, -0 < +0.
REQ-029 Equal operands SHALL return the operand bit pattern, with sign OR (MIN) or sign AND (MAX) for the +0/-0 pair.
REQ-030 Empty pipeline SHALL drive float_out, tag_out, IV as zero.

Reset
REQ-031 On reset all stage valid bits, valid_out, float_out, tag_out and IV SHALL clear to 0 on the next rising edge; in-flight requests SHALL be discarded; ready_out SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-032 Macro FPU_SEL_NAN_PROP_EN defined: SHALL additionally accept FPU_OP_MINIMUM and FPU_OP_MAXIMUM (IEEE 754-2019), identical to MIN/MAX except any NaN operand yields canonical qNaN, IV per REQ-025.
REQ-033 Macro FPU_SEL_NAN_PROP_EN undefined: those op codes SHALL be treated as unsupported per REQ-017 and no propagation logic SHALL be present.

Verification
REQ-034 Defaults, ready_in=1: MIN a=3f800000 b=40000000 tag=5 -> after 2 cycles float_out=3f800000, tag_out=5, IV=0.
REQ-035 MAX a=80000000 b=00000000 -> 00000000; MIN same operands -> 80000000.
REQ-036 MIN a=7f800001 (sNaN) b=40400000 -> 40400000, IV=1; MAX a=7fc00000 b=ffc00000 -> 7fc00000, IV=0.
REQ-037 Back-to-back 8 requests, ready_in=0 for 5 cycles mid-stream -> ready_out falls when STAGES entries held, all 8 results emerge in order with correct tags, none dropped or repeated.
REQ-038 Reset asserted with 2 requests in flight -> valid_out=0 next cycle, no stale result later; op=FPU_OP_ADD with valid_in=1 -> no output produced.
REQ-039 With FPU_SEL_NAN_PROP_EN: MINIMUM a=7fc00000 b=3f800000 -> 7fc00000, IV=0; without it, same request -> no output.
